// File: rtl/key_pkg.sv
// key_pkg: shared defaults and helpers for the key_sync_mode front end.
//   KEY_SYNC_STAGES_DEF : default synchroniser depth per channel
//   KEY_DEBOUNCE_DEF    : default debounce length in clk cycles
//   KEY_NMODES_DEF      : default width of the one-hot mode vector
//   lowest_set_index()  : index of the lowest set bit, 0 when none set
package key_pkg;

    localparam int KEY_SYNC_STAGES_DEF = 2;
    localparam int KEY_DEBOUNCE_DEF    = 4;
    localparam int KEY_NMODES_DEF      = 3;

    // Scans the low 'width' bits of vec; an all-zero vector reports 0 so the
    // encoder output is well defined on idle cycles.
    function automatic int lowest_set_index(input logic [31:0] vec, input int width);
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < width && vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key channel -- synchroniser, debounce counter, filtered
// level and a one-cycle strobe on each accepted rising edge.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   key    : raw asynchronous key input, active-high
//   level  : debounced key level
//   strobe : high for the first cycle level reads 1 after a 0->1 change
module key_debounce
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = KEY_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic strobe
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key};
            strobe <= 1'b0;
            if (synced == level) begin
                // any agreeing cycle restarts qualification
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level  <= synced;
                cnt    <= '0;
                // strobe is registered alongside level so both rise together
                strobe <= synced;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_sync_mode.sv
// key_sync_mode: N-channel key front end with a one-hot mode rotator.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   keys       : raw asynchronous key inputs, active-high
//   level      : debounced key levels
//   strobe     : one-cycle pulse per debounced rising edge
//   any_strobe : OR of strobe
//   keycode    : lowest index with strobe set, 0 when none
//   mode       : one-hot mode, advanced by a press on MODE_KEY
//   mode_first : high while mode is bit 0
module key_sync_mode
    import key_pkg::*;
#(
    parameter int NKEYS           = 4,
    parameter int SYNC_STAGES     = KEY_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
    parameter int NMODES          = KEY_NMODES_DEF,
    parameter int MODE_KEY        = 0,
    localparam int KW             = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NKEYS-1:0]  keys,
    output logic [NKEYS-1:0]  level,
    output logic [NKEYS-1:0]  strobe,
    output logic              any_strobe,
    output logic [KW-1:0]     keycode,
    output logic [NMODES-1:0] mode,
    output logic              mode_first
);

    localparam logic [NMODES-1:0] MODE_RESET = NMODES'(1);

    for (genvar g = 0; g < NKEYS; g++) begin : g_chan
        key_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .key    (keys[g]),
            .level  (level[g]),
            .strobe (strobe[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= MODE_RESET;
        end else if (strobe[MODE_KEY]) begin
            // a corrupted (non-one-hot) mode recovers to bit 0 on the next advance
            if ($onehot(mode)) begin
                mode <= {mode[NMODES-2:0], mode[NMODES-1]};
            end else begin
                mode <= MODE_RESET;
            end
        end
    end

    assign any_strobe = |strobe;
    assign keycode    = KW'(lowest_set_index(32'(strobe), NKEYS));
    assign mode_first = (mode == MODE_RESET);

endmodule

// File: tb/tb_key_sync_mode.sv
module tb_key_sync_mode;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys;
    logic [3:0] level;
    logic [3:0] strobe;
    logic       any_strobe;
    logic [1:0] keycode;
    logic [2:0] mode;
    logic       mode_first;

    int errors = 0;
    int checks = 0;

    key_sync_mode dut (
        .clk        (clk),
        .rst        (rst),
        .keys       (keys),
        .level      (level),
        .strobe     (strobe),
        .any_strobe (any_strobe),
        .keycode    (keycode),
        .mode       (mode),
        .mode_first (mode_first)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // press key idx, expect strobe on the 6th edge and mode update on the 7th,
    // then release and expect level to fall 6 edges later
    task automatic press_release(input int idx, input logic [2:0] prev_mode,
                                 input logic [2:0] next_mode);
        logic [3:0] bit_mask;
        bit_mask  = 4'(1 << idx);
        keys[idx] = 1'b1;
        repeat (5) tick();
        check("pre_strobe", 32'(strobe), 32'h0);
        check("pre_level", 32'(level[idx]), 32'h0);
        tick();
        check("strobe", 32'(strobe), 32'(bit_mask));
        check("level_up", 32'(level[idx]), 32'h1);
        check("any_strobe", 32'(any_strobe), 32'h1);
        check("keycode", 32'(keycode), 32'(idx));
        check("mode_hold", 32'(mode), 32'(prev_mode));
        tick();
        check("strobe_drop", 32'(strobe), 32'h0);
        check("mode_next", 32'(mode), 32'(next_mode));
        check("mode_first", 32'(mode_first), 32'(next_mode == 3'b001));
        keys[idx] = 1'b0;
        repeat (5) tick();
        check("rel_level_hold", 32'(level[idx]), 32'h1);
        tick();
        check("rel_level_fall", 32'(level[idx]), 32'h0);
        check("rel_no_strobe", 32'(strobe), 32'h0);
        repeat (2) tick();
    endtask

    initial begin
        int nstrobe;

        // reset with all keys high
        rst  = 1'b1;
        keys = 4'b1111;
        repeat (2) tick();
        check("rst_level", 32'(level), 32'h0);
        check("rst_strobe", 32'(strobe), 32'h0);
        check("rst_mode", 32'(mode), 32'h1);
        check("rst_mode_first", 32'(mode_first), 32'h1);
        check("rst_keycode", 32'(keycode), 32'h0);
        check("rst_any", 32'(any_strobe), 32'h0);
        rst  = 1'b0;
        keys = 4'b0000;
        repeat (3) tick();

        // clean presses on the mode key
        press_release(0, 3'b001, 3'b010);
        press_release(0, 3'b010, 3'b100);
        press_release(0, 3'b100, 3'b001);
        press_release(0, 3'b001, 3'b010);

        // 3-cycle glitch on key 2 never qualifies
        keys[2] = 1'b1;
        repeat (3) tick();
        keys[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_level", 32'(level[2]), 32'h0);
            check("glitch_strobe", 32'(strobe[2]), 32'h0);
        end

        // 4-cycle pulse on key 2 qualifies exactly once
        keys[2] = 1'b1;
        repeat (4) tick();
        keys[2] = 1'b0;
        repeat (2) tick();
        check("pulse4_strobe", 32'(strobe), 32'h4);
        check("pulse4_keycode", 32'(keycode), 32'h2);
        check("pulse4_level", 32'(level[2]), 32'h1);
        tick();
        check("pulse4_strobe_drop", 32'(strobe), 32'h0);
        check("pulse4_mode", 32'(mode), 32'h2);
        repeat (5) tick();
        check("pulse4_level_fall", 32'(level[2]), 32'h0);

        // simultaneous keys 1 and 3
        keys = 4'b1010;
        repeat (6) tick();
        check("simul_strobe", 32'(strobe), 32'ha);
        check("simul_any", 32'(any_strobe), 32'h1);
        check("simul_keycode", 32'(keycode), 32'h1);
        tick();
        check("simul_mode", 32'(mode), 32'h2);
        keys = 4'b0000;
        repeat (10) tick();
        check("simul_level_fall", 32'(level), 32'h0);

        // long hold on key 0: single strobe, single mode advance
        nstrobe = 0;
        keys[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (strobe[0]) nstrobe++;
        end
        check("hold_level", 32'(level[0]), 32'h1);
        keys[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (strobe[0]) nstrobe++;
            if (i == 5) check("hold_rel_level_hold", 32'(level[0]), 32'h1);
            if (i == 6) check("hold_rel_level_fall", 32'(level[0]), 32'h0);
        end
        check("hold_nstrobe", 32'(nstrobe), 32'h1);
        check("hold_mode", 32'(mode), 32'h4);
        repeat (2) tick();

        // reset in mid-qualification with key held
        keys[0] = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("midrst_mode", 32'(mode), 32'h1);
        check("midrst_level", 32'(level), 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_pre_strobe", 32'(strobe), 32'h0);
        tick();
        check("midrst_strobe", 32'(strobe), 32'h1);
        check("midrst_level_up", 32'(level[0]), 32'h1);
        tick();
        check("midrst_mode_next", 32'(mode), 32'h2);
        check("midrst_mode_first", 32'(mode_first), 32'h0);
        keys[0] = 1'b0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
